// File: rtl/disp_flipctrl.sv
// Page-flip sequencer: brings the display up, then commits each requested
// frame-buffer address to DISPADDR only after a fresh VBLANK is observed.
module disp_flipctrl #(
  parameter int unsigned POLL_GAP   = 8,
  parameter int unsigned POLL_LIMIT = 65535,
  parameter logic [15:0] DISPADDR_A = 16'h0000,
  parameter logic [15:0] DISPCTRL_A = 16'h0004,
  parameter logic [15:0] DISPFIFO_A = 16'h000c
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        ENABLE,
  input  logic        FLIP_REQ,
  input  logic [31:0] FLIP_ADDR,
  output logic        FLIP_ACK,
  output logic        FLIP_DONE,
  output logic        FLIP_ERR,
  output logic        BUSY,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDATA
);

  typedef enum logic [3:0] {
    S_OFF, S_INIT_CTRL, S_INIT_FIFO, S_IDLE, S_RD_CTRL, S_CLR_VB,
    S_POLL, S_GAP, S_WR_ADDR, S_DONE, S_ABORT
  } state_t;

  localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);

  state_t      state, state_nx;
  logic [1:0]  phase;
  logic [7:0]  gap_cnt;
  logic [15:0] poll_cnt;
  logic [31:0] addr_q;
  logic [31:0] rd_q;
  logic        wr_last, rd_last, rd_capture, accept;

  always_comb begin
    wr_last    = (phase == 2'd1);
    rd_capture = (phase == 2'd2);
    rd_last    = (phase == 2'd3);
    accept     = (state == S_IDLE) && ENABLE && FLIP_REQ;
  end

  // Phase restarts on every state change; a POLL->POLL loop (POLL_GAP=0)
  // restarts naturally because the 2-bit phase wraps from 3 to 0.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= S_OFF;
      phase <= '0;
    end else begin
      state <= state_nx;
      phase <= (state_nx != state) ? 2'd0 : phase + 2'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr_q   <= '0;
      rd_q     <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= FLIP_ADDR;
        poll_cnt <= '0;
      end
      if ((state == S_RD_CTRL || state == S_POLL) && rd_capture)
        rd_q <= RDATA;
      if (state == S_POLL && rd_capture)
        poll_cnt <= poll_cnt + 16'd1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_OFF:       if (ENABLE) state_nx = S_INIT_CTRL;
      S_INIT_CTRL: if (wr_last) state_nx = S_INIT_FIFO;
      S_INIT_FIFO: if (wr_last) state_nx = S_IDLE;
      S_IDLE: begin
        if (!ENABLE)       state_nx = S_OFF;
        else if (FLIP_REQ) state_nx = S_RD_CTRL;
      end
      S_RD_CTRL:   if (rd_last) state_nx = S_CLR_VB;
      S_CLR_VB:    if (wr_last) state_nx = S_POLL;
      S_POLL: begin
        if (rd_last) begin
          if (rd_q[1])                state_nx = S_WR_ADDR;
          else if (poll_cnt == LIMIT) state_nx = S_ABORT;
          else if (POLL_GAP == 0)     state_nx = S_POLL;
          else                        state_nx = S_GAP;
        end
      end
      S_GAP:       if (gap_cnt == GAP_LAST) state_nx = S_POLL;
      S_WR_ADDR:   if (wr_last) state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
      S_ABORT:     state_nx = S_IDLE;
      default:     state_nx = S_OFF;
    endcase
  end

  always_comb begin
    FLIP_ACK  = 1'b0;
    FLIP_DONE = 1'b0;
    FLIP_ERR  = 1'b0;
    WRADDR    = '0;
    BYTEEN    = '0;
    WREN      = 1'b0;
    WDATA     = '0;
    RDADDR    = '0;
    RDEN      = 1'b0;
    BUSY      = (state != S_IDLE) && (state != S_OFF);
    case (state)
      S_INIT_CTRL: begin
        WRADDR = DISPCTRL_A;
        BYTEEN = 4'b0001;
        WDATA  = 32'h0000_0001;
        WREN   = wr_last;
      end
      S_INIT_FIFO: begin
        WRADDR = DISPFIFO_A;
        BYTEEN = 4'b0001;
        WDATA  = 32'h0000_0003;
        WREN   = wr_last;
      end
      S_IDLE: FLIP_ACK = ENABLE;
      S_RD_CTRL, S_POLL: begin
        RDADDR = DISPCTRL_A;
        RDEN   = (phase == 2'd1) || (phase == 2'd2);
      end
      S_CLR_VB: begin
        WRADDR = DISPCTRL_A;
        BYTEEN = 4'b0001;
        WDATA  = rd_q | 32'h0000_0002;
        WREN   = wr_last;
      end
      S_WR_ADDR: begin
        WRADDR = DISPADDR_A;
        BYTEEN = 4'b1111;
        WDATA  = addr_q;
        WREN   = wr_last;
      end
      S_DONE: FLIP_DONE = 1'b1;
      S_ABORT: begin
        FLIP_DONE = 1'b1;
        FLIP_ERR  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_disp_flipctrl.sv
// Bench for disp_flipctrl: a DISPCTRL register model whose VBLANK bit rises a
// chosen number of cycles after being cleared, plus a bus monitor and log queues.
module tb_disp_flipctrl;

  localparam int unsigned G   = 12;
  localparam int unsigned LIM = 4;
  localparam logic [15:0] A_ADDR = 16'h0000;
  localparam logic [15:0] A_CTRL = 16'h0004;
  localparam logic [15:0] A_FIFO = 16'h000c;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        ENABLE = 1'b0;
  logic        FLIP_REQ = 1'b0;
  logic [31:0] FLIP_ADDR = '0;
  logic        FLIP_ACK, FLIP_DONE, FLIP_ERR, BUSY, WREN, RDEN;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic [31:0] WDATA, RDATA;

  disp_flipctrl #(.POLL_GAP(G), .POLL_LIMIT(LIM)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .FLIP_REQ(FLIP_REQ),
    .FLIP_ADDR(FLIP_ADDR), .FLIP_ACK(FLIP_ACK), .FLIP_DONE(FLIP_DONE),
    .FLIP_ERR(FLIP_ERR), .BUSY(BUSY), .WRADDR(WRADDR), .BYTEEN(BYTEEN),
    .WREN(WREN), .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_cmp = 0, n_err = 0;

  // DISPCTRL model: bit1 is write-1-to-clear and rises vb_delay cycles later (0 = never).
  logic        dispon = 1'b0, vb = 1'b0, vb_rose = 1'b0;
  int unsigned vb_cnt = 0, vb_delay = 0;
  always @(posedge ACLK) begin
    if (WREN && WRADDR == A_CTRL) begin
      dispon <= WDATA[0];
      if (WDATA[1]) begin
        vb      <= 1'b0;
        vb_rose <= 1'b0;
        vb_cnt  <= vb_delay;
      end
    end else if (vb_cnt != 0) begin
      if (vb_cnt == 1) begin
        vb      <= 1'b1;
        vb_rose <= 1'b1;
      end
      vb_cnt <= vb_cnt - 1;
    end
  end
  always_comb RDATA = {30'd0, vb, dispon};

  // Monitor logs
  int unsigned cyc = 0;
  logic [51:0] wr_q[$];
  int unsigned wr_cyc_q[$], rd_cyc_q[$], ack_q[$], done_q[$];
  logic        vbr_q[$];
  int unsigned rd_cnt = 0, done_cnt = 0, err_cnt = 0;
  int unsigned strobe_errs = 0, form_errs = 0, err_nodone = 0;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin : monitor
    logic        p_wren, p_rden;
    logic [15:0] p_wa, p_ra;
    logic [31:0] p_wd;
    logic [3:0]  p_be;
    int unsigned rd_run;
    p_wren = 0; p_rden = 0; p_wa = '0; p_ra = '0; p_wd = '0; p_be = '0; rd_run = 0;
    forever begin
      @(negedge ACLK);
      if (WREN && RDEN) strobe_errs++;
      if (FLIP_ACK && BUSY) strobe_errs++;
      if (WREN) begin
        if (p_wren || p_wa !== WRADDR || p_wd !== WDATA || p_be !== BYTEEN) form_errs++;
        wr_q.push_back({WRADDR, BYTEEN, WDATA});
        wr_cyc_q.push_back(cyc);
        if (WRADDR == A_ADDR) vbr_q.push_back(vb_rose);
      end
      if (RDEN) begin
        if (!p_rden) begin
          rd_cnt++;
          rd_cyc_q.push_back(cyc);
          if (p_ra !== RDADDR) form_errs++;
        end
        rd_run++;
      end else begin
        if (p_rden && ARESETN && rd_run != 2) form_errs++;
        rd_run = 0;
      end
      if (FLIP_DONE) begin done_cnt++; done_q.push_back(cyc); end
      if (FLIP_ERR) begin err_cnt++; if (!FLIP_DONE) err_nodone++; end
      if (FLIP_ACK) ack_q.push_back(cyc);
      p_wren = WREN; p_rden = RDEN; p_wa = WRADDR; p_ra = RDADDR; p_wd = WDATA; p_be = BYTEEN;
    end
  end

  task automatic clear_logs();
    wr_q.delete(); wr_cyc_q.delete(); rd_cyc_q.delete(); ack_q.delete();
    done_q.delete(); vbr_q.delete();
    rd_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  function automatic logic [51:0] ent(logic [15:0] a, logic [3:0] b, logic [31:0] d);
    return {a, b, d};
  endfunction

  // Captures land 3, 3+(G+4), ... cycles after the clear write; VBLANK rising
  // d cycles after that write is seen by the first capture strictly later.
  function automatic int unsigned exp_polls(int unsigned d);
    int unsigned k = 1;
    while (k < LIM && (d == 0 || 3 + (k - 1) * (G + 4) <= d)) k++;
    return k;
  endfunction

  task automatic run_flip(input logic [31:0] a, input int unsigned d, output bit tmo);
    vb_delay = d;
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK);
    FLIP_REQ = 1'b1; FLIP_ADDR = a;
    tmo = 1;
    for (int i = 0; i < 50; i++) begin
      if (FLIP_ACK) begin tmo = 0; break; end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    FLIP_REQ = 1'b0; FLIP_ADDR = $urandom();
    if (!tmo) begin
      tmo = 1;
      for (int i = 0; i < 2000; i++) begin
        if (done_cnt > 0) begin tmo = 0; break; end
        @(negedge ACLK);
      end
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; ENABLE = 1'b0; FLIP_REQ = 1'b0;
    repeat (3) @(negedge ACLK);
    n_cmp++; if (FLIP_ACK !== 1'b0)  begin n_err++; $display("FAIL reset_ack: got %b want 0", FLIP_ACK); end
    n_cmp++; if (FLIP_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", FLIP_DONE); end
    n_cmp++; if (FLIP_ERR !== 1'b0)  begin n_err++; $display("FAIL reset_err: got %b want 0", FLIP_ERR); end
    n_cmp++; if (BUSY !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (WREN !== 1'b0)      begin n_err++; $display("FAIL reset_wren: got %b want 0", WREN); end
    n_cmp++; if (RDEN !== 1'b0)      begin n_err++; $display("FAIL reset_rden: got %b want 0", RDEN); end
    n_cmp++; if (WRADDR !== 16'h0)   begin n_err++; $display("FAIL reset_wraddr: got %h want 0", WRADDR); end
    n_cmp++; if (RDADDR !== 16'h0)   begin n_err++; $display("FAIL reset_rdaddr: got %h want 0", RDADDR); end
    n_cmp++; if (WDATA !== 32'h0)    begin n_err++; $display("FAIL reset_wdata: got %h want 0", WDATA); end
    n_cmp++; if (BYTEEN !== 4'h0)    begin n_err++; $display("FAIL reset_byteen: got %h want 0", BYTEEN); end
  endtask

  task automatic test_off();
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK); ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    n_cmp++; if (wr_q.size() !== 0) begin n_err++; $display("FAIL off_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (BUSY !== 1'b0 || FLIP_ACK !== 1'b0) begin n_err++; $display("FAIL off_idle: got busy=%b ack=%b want 0/0", BUSY, FLIP_ACK); end
  endtask

  task automatic test_init(input string tag);
    bit tmo = 1;
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK); ENABLE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (FLIP_ACK) begin tmo = 0; break; end
      @(negedge ACLK);
    end
    n_cmp++; if (tmo) begin n_err++; $display("FAIL %s_ack_timeout: got none want FLIP_ACK", tag); end
    n_cmp++; if (wr_q.size() !== 2) begin n_err++; $display("FAIL %s_nwrites: got %0d want 2", tag, wr_q.size()); end
    n_cmp++; if (wr_q.size() > 0 && wr_q[0] !== ent(A_CTRL, 4'b0001, 32'h1))
      begin n_err++; $display("FAIL %s_wr0: got %h want %h", tag, wr_q[0], ent(A_CTRL, 4'b0001, 32'h1)); end
    n_cmp++; if (wr_q.size() > 1 && wr_q[1] !== ent(A_FIFO, 4'b0001, 32'h3))
      begin n_err++; $display("FAIL %s_wr1: got %h want %h", tag, wr_q[1], ent(A_FIFO, 4'b0001, 32'h3)); end
    n_cmp++; if (wr_cyc_q.size() < 2 || ack_q.size() < 1 || ack_q[0] !== wr_cyc_q[1] + 1)
      begin n_err++; $display("FAIL %s_ack_timing: got %0d want %0d", tag, (ack_q.size() > 0) ? ack_q[0] : 0, (wr_cyc_q.size() > 1) ? wr_cyc_q[1] + 1 : 0); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b want 0", tag, BUSY); end
  endtask

  task automatic test_flip();
    logic [31:0] a;
    int unsigned d, np;
    bit tmo;
    logic [51:0] exp_q[$];
    for (int n = 0; n < 7; n++) begin
      a = (n == 0) ? 32'h2012C000 : $urandom();
      d = (n == 0) ? 40 : $urandom_range(50, 1);
      np = exp_polls(d);
      run_flip(a, d, tmo);
      exp_q = '{ent(A_CTRL, 4'b0001, 32'h3), ent(A_ADDR, 4'b1111, a)};
      n_cmp++; if (tmo) begin n_err++; $display("FAIL flip%0d_timeout: got none want FLIP_DONE", n); end
      n_cmp++; if (wr_q.size() !== exp_q.size()) begin n_err++; $display("FAIL flip%0d_nwrites: got %0d want %0d", n, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (i >= wr_q.size() || wr_q[i] !== exp_q[i])
          begin n_err++; $display("FAIL flip%0d_wr%0d: got %h want %h", n, i, (i < wr_q.size()) ? wr_q[i] : 52'h0, exp_q[i]); end
      end
      n_cmp++; if (rd_cnt !== np + 1) begin n_err++; $display("FAIL flip%0d_reads: got %0d want %0d (d=%0d)", n, rd_cnt, np + 1, d); end
      n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_err++; $display("FAIL flip%0d_done_err: got %0d/%0d want 1/0", n, done_cnt, err_cnt); end
      n_cmp++; if (vbr_q.size() !== 1 || vbr_q[0] !== 1'b1) begin n_err++; $display("FAIL flip%0d_fresh_vblank: got %0d entries want one fresh", n, vbr_q.size()); end
      n_cmp++; if (wr_cyc_q.size() < 1 || rd_cyc_q.size() < 2 || wr_cyc_q[0] >= rd_cyc_q[1])
        begin n_err++; $display("FAIL flip%0d_clear_first: got clear at %0d want before first poll", n, (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : 0); end
    end
  endtask

  task automatic test_timeout();
    bit tmo;
    run_flip($urandom(), 0, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL tmo_done_timeout: got none want FLIP_DONE"); end
    n_cmp++; if (rd_cnt !== LIM + 1) begin n_err++; $display("FAIL tmo_reads: got %0d want %0d", rd_cnt, LIM + 1); end
    n_cmp++; if (wr_q.size() !== 1 || wr_q[0] !== ent(A_CTRL, 4'b0001, 32'h3))
      begin n_err++; $display("FAIL tmo_writes: got %0d writes want only the clear", wr_q.size()); end
    n_cmp++; if (done_cnt !== 1 || err_cnt !== 1) begin n_err++; $display("FAIL tmo_done_err: got %0d/%0d want 1/1", done_cnt, err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1 = 32'h20000000, a2 = 32'h2012C000;
    logic [51:0] exp_q[$];
    int unsigned between = 0, between_cyc = 0;
    bit tmo = 1;
    vb_delay = $urandom_range(30, 1);
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK); FLIP_REQ = 1'b1; FLIP_ADDR = a1;
    for (int i = 0; i < 50; i++) begin
      if (FLIP_ACK) begin tmo = 0; break; end
      @(negedge ACLK);
    end
    @(negedge ACLK); FLIP_ADDR = a2;
    if (!tmo) begin
      tmo = 1;
      for (int i = 0; i < 1000; i++) begin
        if (FLIP_ACK) begin tmo = 0; break; end
        @(negedge ACLK);
      end
    end
    @(negedge ACLK); FLIP_REQ = 1'b0;
    for (int i = 0; i < 1000 && done_cnt < 2; i++) @(negedge ACLK);
    @(negedge ACLK);
    exp_q = '{ent(A_CTRL, 4'b0001, 32'h3), ent(A_ADDR, 4'b1111, a1),
              ent(A_CTRL, 4'b0001, 32'h3), ent(A_ADDR, 4'b1111, a2)};
    n_cmp++; if (tmo || done_cnt !== 2) begin n_err++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
    n_cmp++; if (wr_q.size() !== 4) begin n_err++; $display("FAIL b2b_nwrites: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i])
        begin n_err++; $display("FAIL b2b_wr%0d: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 52'h0, exp_q[i]); end
    end
    if (wr_cyc_q.size() == 4)
      foreach (ack_q[i]) if (ack_q[i] > wr_cyc_q[1] && ack_q[i] < wr_cyc_q[3]) begin between++; between_cyc = ack_q[i]; end
    n_cmp++; if (between !== 1) begin n_err++; $display("FAIL b2b_ack_count: got %0d want 1", between); end
    n_cmp++; if (done_q.size() < 1 || between_cyc !== done_q[0] + 1)
      begin n_err++; $display("FAIL b2b_ack_cycle: got %0d want %0d", between_cyc, (done_q.size() > 0) ? done_q[0] + 1 : 0); end
  endtask

  task automatic test_reset_mid();
    bit tmo = 1;
    vb_delay = 0;
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK); FLIP_REQ = 1'b1; FLIP_ADDR = $urandom();
    for (int i = 0; i < 50 && !FLIP_ACK; i++) @(negedge ACLK);
    @(negedge ACLK); FLIP_REQ = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (RDEN && rd_cnt >= 2) begin tmo = 0; break; end
      @(negedge ACLK);
    end
    n_cmp++; if (tmo) begin n_err++; $display("FAIL rstmid_poll_timeout: got no poll want RDEN"); end
    ARESETN = 1'b0;
    @(negedge ACLK);
    n_cmp++; if (RDEN !== 1'b0 || FLIP_ACK !== 1'b0 || BUSY !== 1'b0)
      begin n_err++; $display("FAIL rstmid_outputs: got rden=%b ack=%b busy=%b want 0/0/0", RDEN, FLIP_ACK, BUSY); end
    @(negedge ACLK);
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
    ARESETN = 1'b1; ENABLE = 1'b0;
    test_init("reinit");
  endtask

  task automatic test_disable();
    @(posedge ACLK); #1 clear_logs();
    @(negedge ACLK); ENABLE = 1'b0;
    @(negedge ACLK);
    n_cmp++; if (FLIP_ACK !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL disable_off: got ack=%b busy=%b want 0/0", FLIP_ACK, BUSY); end
    repeat (4) @(negedge ACLK);
    n_cmp++; if (wr_q.size() !== 0 || rd_cnt !== 0) begin n_err++; $display("FAIL disable_bus: got %0d/%0d want 0/0", wr_q.size(), rd_cnt); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (strobe_errs !== 0) begin n_err++; $display("FAIL proto_strobes: got %0d want 0", strobe_errs); end
    n_cmp++; if (form_errs !== 0) begin n_err++; $display("FAIL proto_bus_form: got %0d want 0", form_errs); end
    n_cmp++; if (err_nodone !== 0) begin n_err++; $display("FAIL proto_err_alone: got %0d want 0", err_nodone); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_off();
    test_init("init");
    test_flip();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_disable();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
